// File: rtl/word_request_encoder_if.sv
// Request/offer bus between the requesters, the encoder and its consumer.
interface word_request_encoder_if;
    logic [7:0] req;
    logic       ready;
    logic       valid;
    logic [2:0] addr;
    logic [7:0] grant;

    // Encoder side: samples requests and the consumer's ready, drives the offer.
    modport slave (
        input  req,
        input  ready,
        output valid,
        output addr,
        output grant
    );

    // Requester/consumer side.
    modport master (
        output req,
        output ready,
        input  valid,
        input  addr,
        input  grant
    );
endinterface

// File: rtl/word_request_encoder.sv
// Round-robin word-request encoder: picks one of 8 request lines starting at a
// rotating pointer, offers its inverted index as addr plus a one-hot grant,
// and holds the offer until the consumer accepts it.
module word_request_encoder (
    input  logic                    clk,
    input  logic                    rst,
    word_request_encoder_if.slave   bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] ptr_q,   ptr_d;
    logic [2:0] addr_q,  addr_d;
    logic [7:0] grant_q, grant_d;
    logic       valid_q, valid_d;

    logic [2:0] idx_sel;
    logic       found;

    // Round-robin scan: first set request at ptr, ptr+1, ... wrapping mod 8.
    always_comb begin
        logic [2:0] pos;
        idx_sel = '0;
        found   = 1'b0;
        pos     = '0;
        for (int unsigned k = 0; k < 8; k++) begin
            pos = ptr_q + 3'(k);
            if (!found && bus.req[pos]) begin
                idx_sel = pos;
                found   = 1'b1;
            end
        end
    end

    // Next-state and offer logic; the granted index is recovered as ~addr_q.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    addr_d  = ~idx_sel;
                    grant_d = 8'b1 << idx_sel;
                    valid_d = 1'b1;
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (bus.ready) begin
                    ptr_d   = ~addr_q + 3'd1;
                    grant_d = '0;
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            addr_q  <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
        end
    end

    assign bus.valid = valid_q;
    assign bus.addr  = addr_q;
    assign bus.grant = grant_q;

endmodule

// File: tb/tb_word_request_encoder.sv
// Directed bench for word_request_encoder with hand-computed expectations.
module tb_word_request_encoder;

    logic clk;
    logic rst;
    int unsigned n_checks;
    int unsigned n_pass;

    word_request_encoder_if bus ();

    word_request_encoder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %02h expected %02h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_offer(input string tag, input logic [7:0] g, input logic [2:0] a);
        check({tag, ".valid"}, {7'd0, bus.valid}, 8'd1);
        check({tag, ".grant"}, bus.grant, g);
        check({tag, ".addr"},  {5'd0, bus.addr}, {5'd0, a});
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, {7'd0, bus.valid}, 8'd0);
        check({tag, ".grant"}, bus.grant, 8'h00);
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        bus.req   = 8'h00;
        bus.ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        rst       = 1'b1;
        bus.req   = 8'h00;
        bus.ready = 1'b0;

        // Reset state
        do_reset();
        check_idle("reset");
        check("reset.addr", {5'd0, bus.addr}, 8'h00);

        // No requests, ready toggling: nothing offered
        for (int i = 0; i < 10; i++) begin
            bus.ready = i[0];
            step();
            check_idle("noreq");
        end

        // Single request, consumer stalled: offer holds
        do_reset();
        bus.req   = 8'h01;
        bus.ready = 1'b0;
        step();
        check_offer("line0", 8'h01, 3'b111);
        for (int i = 0; i < 4; i++) begin
            step();
            check_offer("line0.hold", 8'h01, 3'b111);
        end

        // Two lines, always ready: 0, idle, 7, idle, 0
        do_reset();
        bus.req   = 8'h81;
        bus.ready = 1'b1;
        step(); check_offer("rr81.a", 8'h01, 3'b111);
        step(); check_idle("rr81.gap1");
        step(); check_offer("rr81.b", 8'h80, 3'b000);
        step(); check_idle("rr81.gap2");
        step(); check_offer("rr81.c", 8'h01, 3'b111);

        // All lines, always ready: full rotation with wrap
        do_reset();
        bus.req   = 8'hFF;
        bus.ready = 1'b1;
        begin
            logic [7:0] g;
            logic [2:0] a;
            g = 8'h01;
            a = 3'd7;
            for (int k = 0; k < 9; k++) begin
                step(); check_offer("rrFF", g, a);
                step(); check_idle("rrFF.gap");
                g = {g[6:0], g[7]};
                a = a - 3'd1;
            end
        end

        // Offer on line 5 held through req drop and stall
        do_reset();
        bus.req   = 8'h20;
        bus.ready = 1'b0;
        step(); check_offer("line5", 8'h20, 3'b010);
        bus.req = 8'h00;
        for (int i = 0; i < 5; i++) begin
            step(); check_offer("line5.hold", 8'h20, 3'b010);
        end
        bus.ready = 1'b1;
        step(); check_idle("line5.ack");

        // Async reset aborts offer; scan restarts from line 0
        do_reset();
        bus.req   = 8'h04;
        bus.ready = 1'b1;
        step(); check_offer("line2", 8'h04, 3'b101);
        step(); check_idle("line2.ack");
        bus.req   = 8'h08;
        bus.ready = 1'b0;
        step(); check_offer("line3", 8'h08, 3'b100);
        #3;
        rst = 1'b1;
        #1;
        check_idle("async_rst");
        check("async_rst.addr", {5'd0, bus.addr}, 8'h00);
        bus.req = 8'hFF;
        step();
        rst = 1'b0;
        step(); check_offer("post_rst", 8'h01, 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
